seg7_message_decoder: RTL and testbench

//   Receive end of the 7-segment letter stream. Samples a common-anode (active-low) segment bus

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_glyph_decode.sv | 28 ++
 rtl/seg7_message_decoder.sv | 119 +++++++++++
 tb/tb_seg7_message_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Glyph segment patterns (bits G..A, active-low) and the 4-bit character codes they decode to.
// Also holds the code sequences of the two words the receiver watches for.
package seg7_pkg;

   localparam logic [3:0] CH_H       = 4'd0;
   localparam logic [3:0] CH_E       = 4'd1;
   localparam logic [3:0] CH_L       = 4'd2;
   localparam logic [3:0] CH_O       = 4'd3;
   localparam logic [3:0] CH_BLANK   = 4'd4;
   localparam logic [3:0] CH_A       = 4'd5;
   localparam logic [3:0] CH_S       = 4'd6;
   localparam logic [3:0] CH_I       = 4'd7;
   localparam logic [3:0] CH_C       = 4'd8;
   localparam logic [3:0] CH_UNKNOWN = 4'd15;

   localparam logic [6:0] SEG_H     = 7'b0001001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_L     = 7'b1000111;
   localparam logic [6:0] SEG_O     = 7'b1000000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_S     = 7'b0010010;
   localparam logic [6:0] SEG_I     = 7'b1001111;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Oldest character sits in the most significant nibble.
   localparam logic [19:0] HELLO_SEQ = {CH_H, CH_E, CH_L, CH_L, CH_O};
   localparam logic [15:0] ASIC_SEQ  = {CH_A, CH_S, CH_I, CH_C};

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational active-low 7-segment pattern to character code; unknown patterns flag o_err.
// Zero latency, no flow control.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_code,
   output logic       o_err
);

   always_comb begin
      o_code = CH_UNKNOWN;
      o_err  = 1'b0;
      case (i_seg)
         SEG_H:     o_code = CH_H;
         SEG_E:     o_code = CH_E;
         SEG_L:     o_code = CH_L;
         SEG_O:     o_code = CH_O;
         SEG_A:     o_code = CH_A;
         SEG_S:     o_code = CH_S;
         SEG_I:     o_code = CH_I;
         SEG_C:     o_code = CH_C;
         SEG_BLANK: o_code = CH_BLANK;
         default:   o_err  = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_message_decoder.sv
// Debounces a sampled 7-segment bus, emits one character per stable hold (plus one per slot of extra hold)
// and pulses on HELLO / ASIC; char_valid lags a new glyph by STABLE_CYCLES+2 edges, no backpressure.
module seg7_message_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int SLOT_CYCLES   = 16
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] seg_n,
   output logic       char_valid,
   output logic [3:0] char_code,
   output logic       char_err,
   output logic       hello_det,
   output logic       asic_det,
   output logic [3:0] word_count
);

   localparam int HW = $clog2(STABLE_CYCLES);
   localparam int SW = $clog2(SLOT_CYCLES);

   logic [6:0]    r_sync1;
   logic [6:0]    r_s;
   logic [6:0]    r_prev;
   logic [HW-1:0] r_hold;
   logic [SW-1:0] r_slot;
   logic          r_locked;
   logic          r_char_valid;
   logic [3:0]    r_char_code;
   logic          r_char_err;
   logic [19:0]   r_hist;
   logic          r_hello;
   logic          r_asic;
   logic [3:0]    r_word_count;

   logic          w_unused_dp;
   logic          w_changed;
   logic          w_accept;
   logic [3:0]    w_code;
   logic          w_err;
   logic          w_hello;
   logic          w_asic;

   assign w_unused_dp = seg_n[7];
   assign w_changed   = (r_s != r_prev);

   // r_prev is the value the counters have been timing, so a change arriving in the
   // accept cycle still emits the glyph that was actually stable.
   assign w_accept = r_locked ? (r_slot == SW'(SLOT_CYCLES - 1))
                              : (r_hold == HW'(STABLE_CYCLES - 1));

   seg7_glyph_decode u_decode (
      .i_seg  (r_prev),
      .o_code (w_code),
      .o_err  (w_err)
   );

   assign w_hello = r_char_valid && (r_hist == HELLO_SEQ);
   assign w_asic  = r_char_valid && (r_hist[15:0] == ASIC_SEQ);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1      <= 7'h7F;
         r_s          <= 7'h7F;
         r_prev       <= 7'h7F;
         r_hold       <= '0;
         r_slot       <= '0;
         r_locked     <= 1'b0;
         r_char_valid <= 1'b0;
         r_char_code  <= CH_BLANK;
         r_char_err   <= 1'b0;
         r_hist       <= {5{CH_BLANK}};
         r_hello      <= 1'b0;
         r_asic       <= 1'b0;
         r_word_count <= 4'd0;
      end else begin
         r_sync1 <= seg_n[6:0];
         r_s     <= r_sync1;
         r_prev  <= r_s;

         if (w_changed) begin
            r_hold   <= '0;
            r_slot   <= '0;
            r_locked <= 1'b0;
         end else if (w_accept) begin
            r_locked <= 1'b1;
            r_slot   <= '0;
         end else if (r_locked) begin
            r_slot <= r_slot + 1'b1;
         end else begin
            r_hold <= r_hold + 1'b1;
         end

         r_char_valid <= w_accept;
         r_char_err   <= w_accept & w_err;
         if (w_accept) begin
            r_char_code <= w_code;
            // An unreadable glyph wipes the history so no word straddles it.
            r_hist      <= w_err ? {5{CH_BLANK}} : {r_hist[15:0], w_code};
         end

         r_hello <= w_hello;
         r_asic  <= w_asic;
         if (w_hello || w_asic) begin
            r_word_count <= r_word_count + 1'b1;
         end
      end
   end

   assign char_valid = r_char_valid;
   assign char_code  = r_char_code;
   assign char_err   = r_char_err;
   assign hello_det  = r_hello;
   assign asic_det   = r_asic;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_seg7_message_decoder.sv
// Scoreboard bench for seg7_message_decoder: each glyph hold pushes its expected characters,
// a negedge monitor pops them as char_valid appears and checks the word pulses one cycle later.
module tb_seg7_message_decoder;

   localparam int STABLE = 4;
   localparam int SLOT   = 16;

   localparam logic [7:0] P_H     = {1'b1, 7'b0001001};
   localparam logic [7:0] P_E     = {1'b1, 7'b0000110};
   localparam logic [7:0] P_L     = {1'b1, 7'b1000111};
   localparam logic [7:0] P_O     = {1'b1, 7'b1000000};
   localparam logic [7:0] P_A     = {1'b1, 7'b0001000};
   localparam logic [7:0] P_S     = {1'b1, 7'b0010010};
   localparam logic [7:0] P_I     = {1'b1, 7'b1001111};
   localparam logic [7:0] P_C     = {1'b1, 7'b1000110};
   localparam logic [7:0] P_BLANK = 8'hFF;
   localparam logic [7:0] P_BAD   = {1'b1, 7'b0100100};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] seg_n = 8'hFF;
   logic       char_valid;
   logic [3:0] char_code;
   logic       char_err;
   logic       hello_det;
   logic       asic_det;
   logic [3:0] word_count;

   seg7_message_decoder #(.STABLE_CYCLES(STABLE), .SLOT_CYCLES(SLOT)) dut (
      .clk        (clk),
      .reset      (reset),
      .seg_n      (seg_n),
      .char_valid (char_valid),
      .char_code  (char_code),
      .char_err   (char_err),
      .hello_det  (hello_det),
      .asic_det   (asic_det),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] code;
      logic       err;
      logic       hello;
      logic       asic;
   } exp_t;

   exp_t       sb_q[$];
   logic [3:0] mh[5];
   logic [3:0] m_wc;
   logic       pend, pend_h, pend_a;
   int         n_checks = 0;
   int         n_fail = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] ref_decode(input logic [6:0] p);
      case (p)
         7'b0001001: return {1'b0, 4'd0};
         7'b0000110: return {1'b0, 4'd1};
         7'b1000111: return {1'b0, 4'd2};
         7'b1000000: return {1'b0, 4'd3};
         7'b1111111: return {1'b0, 4'd4};
         7'b0001000: return {1'b0, 4'd5};
         7'b0010010: return {1'b0, 4'd6};
         7'b1001111: return {1'b0, 4'd7};
         7'b1000110: return {1'b0, 4'd8};
         default:    return {1'b1, 4'd15};
      endcase
   endfunction

   task automatic model_push(input logic [6:0] p);
      logic [4:0] d;
      exp_t e;
      d = ref_decode(p);
      if (d[4]) begin
         for (int i = 0; i < 5; i++) mh[i] = 4'd4;
      end else begin
         for (int i = 4; i > 0; i--) mh[i] = mh[i-1];
         mh[0] = d[3:0];
      end
      e.code  = d[3:0];
      e.err   = d[4];
      e.hello = (mh[4] == 4'd0) && (mh[3] == 4'd1) && (mh[2] == 4'd2) && (mh[1] == 4'd2) && (mh[0] == 4'd3);
      e.asic  = (mh[3] == 4'd5) && (mh[2] == 4'd6) && (mh[1] == 4'd7) && (mh[0] == 4'd8);
      if (e.hello || e.asic) m_wc = m_wc + 4'd1;
      sb_q.push_back(e);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 5; i++) mh[i] = 4'd4;
      m_wc = 4'd0;
      pend = 1'b0;
      pend_h = 1'b0;
      pend_a = 1'b0;
   endtask

   function automatic int n_accepts(input int n);
      return (n < STABLE) ? 0 : 1 + (n - STABLE) / SLOT;
   endfunction

   task automatic hold(input logic [7:0] pat, input int n);
      seg_n = pat;
      repeat (n_accepts(n)) model_push(pat[6:0]);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold_dp_toggle(input logic [7:0] pat, input int n);
      repeat (n_accepts(n)) model_push(pat[6:0]);
      for (int i = 0; i < n; i++) begin
         seg_n = {i[0], pat[6:0]};
         @(negedge clk);
      end
   endtask

   task automatic end_test(input string tag);
      check({tag, "_leftover"}, 8'(sb_q.size()), 8'd0);
      check({tag, "_word_count"}, {4'd0, word_count}, {4'd0, m_wc});
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (pend) begin
            check("hello_det", {7'd0, hello_det}, {7'd0, pend_h});
            check("asic_det", {7'd0, asic_det}, {7'd0, pend_a});
            pend = 1'b0;
         end else begin
            check("det_idle", {6'd0, hello_det, asic_det}, 8'd0);
         end
         if (char_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_char", {4'd0, char_code}, 8'hEE);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("char_code", {4'd0, char_code}, {4'd0, e.code});
               check("char_err", {7'd0, char_err}, {7'd0, e.err});
               pend   = 1'b1;
               pend_h = e.hello;
               pend_a = e.asic;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_char_valid", {7'd0, char_valid}, 8'd0);
      check("rst_char_code", {4'd0, char_code}, 8'd4);
      check("rst_char_err", {7'd0, char_err}, 8'd0);
      check("rst_dets", {6'd0, hello_det, asic_det}, 8'd0);
      check("rst_word_count", {4'd0, word_count}, 8'd0);

      // HELLO with the double L split by hold time
      seg_n = P_H;
      reset = 1'b0;
      hold(P_H, 10);
      hold(P_E, 10);
      hold(P_L, 2 * SLOT);
      hold(P_O, 10);
      end_test("hello");

      // ASIC followed by a blank with dp lit
      hold(P_A, 10);
      hold(P_S, 10);
      hold(P_I, 10);
      hold(P_C, 10);
      hold(8'h7F, 10);
      end_test("asic");

      // reset in the middle of an E hold, then E re-accepted with full latency
      seg_n = P_E;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_char_valid", {7'd0, char_valid}, 8'd0);
      check("midrst_char_code", {4'd0, char_code}, 8'd4);
      check("midrst_char_err", {7'd0, char_err}, 8'd0);
      check("midrst_dets", {6'd0, hello_det, asic_det}, 8'd0);
      check("midrst_word_count", {4'd0, word_count}, 8'd0);
      check("midrst_leftover", 8'(sb_q.size()), 8'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      model_push(P_E[6:0]);
      @(posedge clk);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         n++;
         #1;
         if (char_valid) break;
      end
      check("accept_latency", 8'(n), 8'(STABLE + 2));
      repeat (4) @(negedge clk);
      end_test("reset");

      // short glitch between two H holds
      hold(P_BLANK, 10);
      hold(P_H, 10);
      hold(P_E, STABLE - 1);
      hold(P_H, 10);
      end_test("glitch");

      // unknown glyph in the middle of HELLO breaks the word
      hold(P_BLANK, 10);
      hold(P_H, 10);
      hold(P_E, 10);
      hold(P_BAD, 10);
      hold(P_L, 10);
      hold(P_O, 10);
      end_test("error");

      // dp toggling must not disturb a steady O
      hold(P_BLANK, 10);
      hold_dp_toggle(P_O, 2 * SLOT);
      end_test("dp");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
